// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshake and serial shifter
// Define ALU_FAST_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         control,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     work;
  logic [WIDTH-1:0]     work_next;
  logic [SHAMT_W-1:0]   cnt;
  logic [3:0]           op;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ill;
  logic                 accept;
  logic                 serial_start;
  logic [SHAMT_W-1:0]   shamt;
  logic                 is_shift;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[SHAMT_W-1:0];
  assign is_shift = (control == OP_SLL) || (control == OP_SRL) || (control == OP_SRA);

`ifdef ALU_FAST_SHIFT_EN
  assign serial_start = 1'b0;
`else
  assign serial_start = is_shift && (shamt != '0);
`endif

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (control)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
`else
      // Only reached for shamt == 0; nonzero amounts go through the SHIFT state.
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    work_next = work;
    case (op)
      OP_SLL:  work_next = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  work_next = {1'b0, work[WIDTH-1:1]};
      default: work_next = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result    <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
      cnt       <= '0;
      work      <= '0;
      op        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (serial_start) begin
              work      <= a;
              cnt       <= shamt;
              op        <= control;
              out_valid <= 1'b0;
              state     <= SHIFT;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              illegal   <= alu_ill;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            result    <= work_next;
            zero      <= (work_next == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit with directed and random ops
module tb_alu_exec_unit;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  control;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hold_n = 0;
  bit   ready_rand = 0;
  bit   seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the op-code table.
  function automatic void model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic il, output int lat);
    int sh;
    bit shift_op;
    sh = int'(y[4:0]);
    il = 1'b0;
    lat = 1;
    shift_op = 1'b0;
    case (c)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = x ^ y;
      4'b0100: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b0101: r = (x < y) ? 32'd1 : 32'd0;
      4'b0011: begin r = x << sh; shift_op = 1'b1; end
      4'b1000: begin r = x >> sh; shift_op = 1'b1; end
      4'b1010: begin r = $signed(x) >>> sh; shift_op = 1'b1; end
      default: begin r = 32'd0; il = 1'b1; end
    endcase
    if (shift_op && !FAST && sh > 0) lat = sh + 1;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_n > 0) out_ready = 1'b0;
      else if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q[0];
        if (!seen) begin
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          seen = 1;
        end
        chk("result", 64'(result), 64'(e.res));
        chk("zero", 64'(zero), 64'(e.res == 32'd0));
        chk("illegal", 64'(illegal), 64'(e.ill));
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 0;
        end else begin
          chk("in_ready_while_held", 64'(in_ready), 64'(0));
          if (hold_n > 0) hold_n--;
        end
      end
    end else if (exp_q.size() > 0) begin
      chk("in_ready_while_busy", 64'(in_ready), 64'(0));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                       output int waits);
    exp_t e;
    waits = 0;
    in_valid = 1'b1;
    control = c;
    a = x;
    b = y;
    forever begin
      @(negedge clk);
      #2;
      if (in_ready) break;
      @(posedge clk);
      #1;
      waits++;
      if (waits > 300) begin
        chk("accept_timeout", 64'(waits), 64'(0));
        in_valid = 1'b0;
        return;
      end
    end
    model(c, x, y, e.res, e.ill, e.lat);
    e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    control = 4'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_reset();
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_zero", 64'(zero), 64'(1));
    chk("rst_illegal", 64'(illegal), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    int w;
    logic [31:0] x;
    logic [31:0] y;
    rst_n = 1'b0;
    in_valid = 1'b0;
    control = 4'd0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, w);
    issue(4'b0110, 32'd5, 32'd5, w);
    issue(4'b0100, 32'hFFFF_FFFF, 32'd1, w);
    chk("back_to_back_waits", 64'(w), 64'(0));
    issue(4'b1010, 32'h8000_0000, 32'h0000_001F, w);
    issue(4'b0011, 32'h1, 32'h20, w);
    issue(4'b1000, 32'hF0, 32'd4, w);
    drain();

    hold_n = 3;
    issue(4'b1111, 32'h1234, 32'h5678, w);
    drain();

    issue(4'b0011, 32'd1, 32'd10, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(4'b0010, 32'd2, 32'd3, w);
    drain();

    ready_rand = 1;
    for (int i = 0; i < 150; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) x = {32{x[0]}};
      if ($urandom_range(0, 3) == 0) y = x;
      issue(4'($urandom_range(0, 15)), x, y, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
